// File: rtl/seq_serializer.sv
// seq_serializer: buffers WIDTH-bit words in a DEPTH-entry FIFO and
// emits them one bit per clock on data, flagged by data_valid.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  word handshake, in_data is the word
//   data, data_valid   registered serial bit and its qualifier
//   busy               word in flight or words buffered
module seq_serializer #(
  parameter int WIDTH      = 10,
  parameter int DEPTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             data,
  output logic             data_valid,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic IDLE_BIT = 1'(IDLE_LEVEL);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  state_t           state, state_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             data_n;
  logic             dv_n;

  // Bit at the output end of a word, and the word advanced by one.
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  // Full FIFO refuses input even when a pop happens this cycle.
  assign in_ready = (count != FULL) && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state == SHIFT) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sreg       <= '0;
      data       <= IDLE_BIT;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      sreg       <= sreg_n;
      data       <= data_n;
      data_valid <= dv_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sreg_n    = sreg;
    data_n    = IDLE_BIT;
    dv_n      = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt != '0) begin
          data_n    = first_bit(sreg);
          sreg_n    = advance(sreg);
          bit_cnt_n = bit_cnt - 1'b1;
          dv_n      = 1'b1;
        end else if (count != '0) begin
          pop = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
    // A pop loads the head and drives its first bit on the same edge,
    // which keeps back-to-back words gap-free.
    if (pop) begin
      data_n    = first_bit(head);
      sreg_n    = advance(head);
      bit_cnt_n = LAST;
      dv_n      = 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed checks of seq_serializer in MSB-first
// and LSB-first builds sharing one clock and reset.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0;
  logic [9:0] d0 = '0;
  logic       r0, q0, dv0, b0;
  logic       v1 = 1'b0;
  logic [9:0] d1 = '0;
  logic       r1, q1, dv1, b1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_serializer #(
    .WIDTH(10), .DEPTH(4), .MSB_FIRST(1), .IDLE_LEVEL(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(v0), .in_ready(r0), .in_data(d0),
    .data(q0), .data_valid(dv0), .busy(b0)
  );

  seq_serializer #(
    .WIDTH(10), .DEPTH(4), .MSB_FIRST(0), .IDLE_LEVEL(0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(r1), .in_data(d1),
    .data(q1), .data_valid(dv1), .busy(b1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reassembles dut0 words; a data_valid gap ends any partial word.
  logic [9:0] acc = '0;
  int         nb = 0;
  int         dv_total = 0;
  logic [9:0] rxq[$];

  always @(posedge clk) begin
    #1;
    if (dv0) begin
      dv_total++;
      acc = {acc[8:0], q0};
      nb++;
      if (nb == 10) begin
        rxq.push_back(acc);
        nb = 0;
      end
    end else begin
      nb = 0;
    end
  end

  logic [9:0]  bits;
  logic [9:0]  dvs;
  logic [19:0] bits20;
  logic [19:0] dvs20;
  int          base;

  initial begin
    #1;
    for (int i = 0; i < 5; i++) step();
    check("rst_data", q0, 0);
    check("rst_dv", dv0, 0);
    check("rst_busy", b0, 0);
    check("rst_ready", r0, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", r0, 1);
    check("post_rst_dv", dv0, 0);

    // single word, MSB first
    v0 = 1'b1;
    d0 = 10'b0100100101;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      bits = {bits[8:0], q0};
      dvs  = {dvs[8:0], dv0};
    end
    check("t1_bits", bits, 10'b0100100101);
    check("t1_dv", dvs, 10'h3FF);
    check("t1_busy_last", b0, 1);
    step();
    check("t1_idle_data", q0, 0);
    check("t1_idle_dv", dv0, 0);
    check("t1_idle_busy", b0, 0);

    // back-to-back words
    v0 = 1'b1;
    d0 = 10'h3FF;
    step();
    d0 = 10'h000;
    step();
    v0 = 1'b0;
    bits20 = {19'd0, q0};
    dvs20  = {19'd0, dv0};
    for (int i = 1; i < 20; i++) begin
      step();
      bits20 = {bits20[18:0], q0};
      dvs20  = {dvs20[18:0], dv0};
    end
    check("t2_bits", bits20, 20'hFFC00);
    check("t2_dv", dvs20, 20'hFFFFF);
    step();
    check("t2_end_dv", dv0, 0);

    // FIFO full: five words go in, then in_ready stays low
    step();
    rxq.delete();
    for (int k = 0; k < 10; k++) begin
      v0 = 1'b1;
      d0 = 10'(10'h100 + k);
      #1;
      check($sformatf("t3_ready_%0d", k), r0, (k < 5) ? 1 : 0);
      step();
    end
    v0 = 1'b0;
    for (int i = 0; i < 80 && rxq.size() < 5; i++) step();
    check("t3_count", rxq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      base = 32'h100 + i;
      if (i < rxq.size()) check($sformatf("t3_word_%0d", i), rxq[i], base);
    end
    step();
    step();
    check("t3_no_extra", rxq.size(), 5);
    check("t3_busy", b0, 0);

    // LSB-first build
    v1 = 1'b1;
    d1 = 10'b0000000001;
    step();
    v1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      bits = {bits[8:0], q1};
      dvs  = {dvs[8:0], dv1};
    end
    check("t4_bits", bits, 10'b1000000000);
    check("t4_dv", dvs, 10'h3FF);
    step();
    check("t4_end_dv", dv1, 0);

    // reset mid-word with two words buffered
    rxq.delete();
    v0 = 1'b1;
    d0 = 10'h2AA;
    step();
    d0 = 10'h0F0;
    step();
    d0 = 10'h00F;
    step();
    v0 = 1'b0;
    step();
    step();
    check("t5_pre_dv", dv0, 1);
    rst = 1'b1;
    step();
    check("t5_rst_data", q0, 0);
    check("t5_rst_dv", dv0, 0);
    check("t5_rst_busy", b0, 0);
    check("t5_rst_ready", r0, 0);
    rst = 1'b0;
    base = dv_total;
    for (int i = 0; i < 15; i++) step();
    check("t5_stale_bits", dv_total - base, 0);
    check("t5_stale_words", rxq.size(), 0);
    v0 = 1'b1;
    d0 = 10'h155;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("t5_fresh_count", rxq.size(), 1);
    if (rxq.size() > 0) check("t5_fresh_word", rxq[0], 10'h155);

    // late push: one idle cycle, then the new word
    v0 = 1'b1;
    d0 = 10'h3C5;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      bits = {bits[8:0], q0};
    end
    check("t6_first", bits, 10'h3C5);
    v0 = 1'b1;
    d0 = 10'h0F3;
    step();
    v0 = 1'b0;
    check("t6_gap", dv0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      bits = {bits[8:0], q0};
      dvs  = {dvs[8:0], dv0};
    end
    check("t6_second", bits, 10'h0F3);
    check("t6_dv", dvs, 10'h3FF);
    step();
    check("t6_end_dv", dv0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
